led_match_game: RTL and testbench

- Parametrised successor to the board's LED memory game controller.
- A pseudo-random pattern is flashed on LED_W LEDs; the player reproduces it on the switches inside a timed window.
- Matches score BCD points and advance levels; a level shortens the show time. Mismatches cost lives.
- Sits at the top of the game datapath and drives the LED bank and three active-low 7-segment digits directly.

---
 rtl/led_match_game.sv | 207 ++++++++++++++++++++
 tb/tb_led_match_game.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_match_game.sv
// LED memory game: flash an LFSR pattern, player copies it on the switches.
// Matches score BCD points and raise the level; mismatches cost lives.
module led_match_game #(
    parameter int LED_W            = 10,
    parameter int TICK_DIV         = 50000000,
    parameter int SHOW_BASE        = 8,
    parameter int SHOW_STEP        = 1,
    parameter int INPUT_TICKS      = 6,
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int LEVELS           = 8,
    parameter int LIVES            = 3,
    parameter int OVER_TICKS       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LED_W-1:0] switch,
    output logic [LED_W-1:0] led,
    output logic [6:0]       point_msb,
    output logic [6:0]       point_lsb,
    output logic [6:0]       level_out,
    output logic             splitter,
    output logic [3:0]       state_out
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_SHOW   = 4'd2;
    localparam logic [3:0] S_INPUT  = 4'd3;
    localparam logic [3:0] S_CHECK  = 4'd4;
    localparam logic [3:0] S_RESULT = 4'd5;
    localparam logic [3:0] S_OVER   = 4'd6;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] IN_LAST   = 4'(INPUT_TICKS - 1);
    localparam logic [3:0] OVER_LAST = 4'(OVER_TICKS - 1);
    localparam logic [3:0] RPL_LAST  = 4'(ROUNDS_PER_LEVEL - 1);
    localparam logic [3:0] LV_MAX    = 4'(LEVELS - 1);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    logic [3:0]       state;
    logic [3:0]       state_nx;
    logic [PW-1:0]    presc;
    logic [3:0]       cnt;
    logic             tick;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nx;
    logic             start_q;
    logic             start_edge;
    logic [LED_W-1:0] sw_s1;
    logic [LED_W-1:0] sw_s2;
    logic [LED_W-1:0] pattern;
    logic [LED_W-1:0] captured;
    logic             hit;
    logic             match_q;
    logic [3:0]       score_tens;
    logic [3:0]       score_units;
    logic [3:0]       level;
    logic [3:0]       streak;
    logic [2:0]       lives;
    logic [31:0]      show_red;
    logic [3:0]       show_last;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick       = (presc == PRESC_LAST);
    assign start_edge = start & ~start_q;
    assign hit        = (captured == pattern);
    assign lfsr_nx    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Show time shrinks with level but never drops below one tick.
    always_comb begin
        show_red  = 32'(level) * 32'(SHOW_STEP);
        show_last = 4'd0;
        if (show_red < 32'(SHOW_BASE))
            show_last = 4'(32'(SHOW_BASE) - show_red - 32'd1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_edge) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_SHOW;
            S_SHOW:   if (tick && cnt == show_last) state_nx = S_INPUT;
            S_INPUT:  if (tick && cnt == IN_LAST) state_nx = S_CHECK;
            S_CHECK:  state_nx = (!hit && lives == 3'd1) ? S_OVER : S_RESULT;
            S_RESULT: if (tick) state_nx = S_LOAD;
            S_OVER:   if (tick && cnt == OVER_LAST) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            presc       <= '0;
            cnt         <= '0;
            lfsr        <= 16'hACE1;
            start_q     <= 1'b0;
            sw_s1       <= '0;
            sw_s2       <= '0;
            pattern     <= '0;
            captured    <= '0;
            match_q     <= 1'b0;
            score_tens  <= '0;
            score_units <= '0;
            level       <= '0;
            streak      <= '0;
            lives       <= LIVES_INIT;
        end else begin
            state   <= state_nx;
            lfsr    <= lfsr_nx;
            start_q <= start;
            sw_s1   <= switch;
            sw_s2   <= sw_s1;
            // Restarting the prescaler on entry makes every state tick-aligned.
            if (state_nx != state) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= cnt + 4'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        score_tens  <= '0;
                        score_units <= '0;
                        level       <= '0;
                        streak      <= '0;
                        lives       <= LIVES_INIT;
                    end
                end
                S_LOAD: begin
                    if (lfsr[LED_W-1:0] == '0)
                        pattern <= LED_W'(1);
                    else
                        pattern <= lfsr[LED_W-1:0];
                end
                S_INPUT: begin
                    if (tick && cnt == IN_LAST)
                        captured <= sw_s2;
                end
                S_CHECK: begin
                    match_q <= hit;
                    if (hit) begin
                        if (score_units == 4'd9) begin
                            if (score_tens != 4'd9) begin
                                score_units <= 4'd0;
                                score_tens  <= score_tens + 4'd1;
                            end
                        end else begin
                            score_units <= score_units + 4'd1;
                        end
                        if (streak == RPL_LAST) begin
                            streak <= 4'd0;
                            if (level < LV_MAX)
                                level <= level + 4'd1;
                        end else begin
                            streak <= streak + 4'd1;
                        end
                    end else begin
                        lives  <= lives - 3'd1;
                        streak <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led = '0;
        case (state)
            S_SHOW:   led = pattern;
            S_RESULT: led = match_q ? '1 : pattern;
            S_OVER:   led = cnt[0] ? '0 : '1;
            default:  led = '0;
        endcase
    end

    assign splitter  = (state == S_INPUT);
    assign state_out = state;
    assign point_msb = seg7(score_tens);
    assign point_lsb = seg7(score_units);
    assign level_out = seg7(level);

endmodule

// File: tb/tb_led_match_game.sv
// Bench for led_match_game: scoreboard of expected round outcomes
// checked as each round reaches RESULT or OVER.
module tb_led_match_game;

    localparam int W = 10;

    typedef struct {
        logic [3:0]   st;
        logic [W-1:0] led;
        logic [6:0]   msb;
        logic [6:0]   lsb;
        logic [6:0]   lvl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] led;
    logic [6:0]   msb;
    logic [6:0]   lsb;
    logic [6:0]   lvl;
    logic         splitter;
    logic [3:0]   st;

    logic [15:0]  lfsr_m;
    logic [W-1:0] first_pat;
    exp_t         sb[$];

    int checks = 0;
    int failures = 0;
    int m_score, m_level, m_streak, m_lives;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    led_match_game #(
        .LED_W(W), .TICK_DIV(2), .SHOW_BASE(3), .SHOW_STEP(1),
        .INPUT_TICKS(2), .ROUNDS_PER_LEVEL(2), .LEVELS(3),
        .LIVES(2), .OVER_TICKS(2)
    ) dut (
        .clock(clk), .reset(rst_n), .start(start), .switch(sw),
        .led(led), .point_msb(msb), .point_lsb(lsb),
        .level_out(lvl), .splitter(splitter), .state_out(st)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        while (st != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_s%0d", s), 32'(st), 32'(s));
    endtask

    task automatic run_len(input logic [3:0] s, output int n);
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (st == s && n < 64);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_game();
        m_score  = 0;
        m_level  = 0;
        m_streak = 0;
        m_lives  = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 plain, 1 record first pattern, 2 compare against it
    task automatic play_round(input bit hit, input bit poke, input int mode);
        logic [W-1:0] pat;
        int n;
        int show_t;
        exp_t e;
        wait_state(4'd1, 64);
        pat = lfsr_m[W-1:0];
        if (pat == '0) pat = W'(1);
        if (mode == 1) first_pat = pat;
        @(negedge clk);
        chk("show_st", 32'(st), 32'd2);
        chk("show_led", 32'(led), 32'(pat));
        if (mode == 2) chk("repro_pat", 32'(led), 32'(first_pat));
        sw = hit ? pat : '0;
        show_t = (3 - m_level < 1) ? 1 : 3 - m_level;
        if (hit) begin
            m_score = (m_score < 99) ? m_score + 1 : 99;
            m_streak++;
            if (m_streak == 2) begin
                m_streak = 0;
                if (m_level < 2) m_level++;
            end
            e.st  = 4'd5;
            e.led = '1;
        end else begin
            m_lives--;
            m_streak = 0;
            e.st  = (m_lives == 0) ? 4'd6 : 4'd5;
            e.led = (m_lives == 0) ? '1 : pat;
        end
        e.msb = seg_tab[m_score / 10];
        e.lsb = seg_tab[m_score % 10];
        e.lvl = seg_tab[m_level];
        sb.push_back(e);
        run_len(4'd2, n);
        chk("show_len", 32'(n), 32'(2 * show_t));
        chk("input_st", 32'(st), 32'd3);
        chk("splitter", 32'(splitter), 32'd1);
        chk("input_led", 32'(led), 32'd0);
        if (poke) start = 1'b1;
        run_len(4'd3, n);
        start = 1'b0;
        chk("input_len", 32'(n), 32'd4);
        chk("check_st", 32'(st), 32'd4);
        @(negedge clk);
        e = sb.pop_front();
        chk("res_st", 32'(st), 32'(e.st));
        chk("res_led", 32'(led), 32'(e.led));
        chk("res_msb", 32'(msb), 32'(e.msb));
        chk("res_lsb", 32'(lsb), 32'(e.lsb));
        chk("res_lvl", 32'(lvl), 32'(e.lvl));
        if (e.st == 4'd6) begin
            @(negedge clk);
            chk("over_led2", 32'(led), 32'h3FF);
            @(negedge clk);
            chk("over_led3", 32'(led), 32'h0);
            @(negedge clk);
            chk("over_led4", 32'(led), 32'h0);
            @(negedge clk);
            chk("over_idle", 32'(st), 32'd0);
            chk("keep_lsb", 32'(lsb), 32'(seg_tab[m_score % 10]));
            chk("keep_lvl", 32'(lvl), 32'(seg_tab[m_level]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();
        chk("rst_st", 32'(st), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_msb", 32'(msb), 32'(7'b1000000));
        chk("rst_lsb", 32'(lsb), 32'(7'b1000000));
        chk("rst_lvl", 32'(lvl), 32'(7'b1000000));
        chk("rst_split", 32'(splitter), 32'd0);

        start_game();
        play_round(1'b1, 1'b0, 1);
        for (int i = 0; i < 5; i++) play_round(1'b1, 1'b0, 0);
        play_round(1'b0, 1'b0, 0);
        play_round(1'b0, 1'b0, 0);

        start_game();
        wait_state(4'd2, 64);
        @(negedge clk);
        rst_n = 1'b0;
        sw = '0;
        #1;
        chk("mid_rst_st", 32'(st), 32'd0);
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_msb", 32'(msb), 32'(7'b1000000));
        chk("mid_rst_lsb", 32'(lsb), 32'(7'b1000000));
        chk("mid_rst_lvl", 32'(lvl), 32'(7'b1000000));
        apply_reset();
        start_game();
        play_round(1'b1, 1'b1, 2);
        for (int i = 0; i < 100; i++) play_round(1'b1, 1'b0, 0);
        chk("sat_msb", 32'(msb), 32'(7'b0010000));
        chk("sat_lsb", 32'(lsb), 32'(7'b0010000));
        play_round(1'b0, 1'b0, 0);
        play_round(1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
